// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/flow-control unit.
// Holds the tracker stage-entry layout, the forwarding-select width helper
// and the forwarding-select encoding for "read from register file".
package risc_pipe_pkg;

   // Forwarding select value meaning "operand comes from the register file".
   localparam int FWD_RF = 0;

   // Widest register address the tracker entry can hold. Narrower register
   // files are zero-extended into this field so one struct type serves all
   // parameterisations of the unit.
   localparam int MAX_REG_AW = 8;

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic                  valid;
      logic [MAX_REG_AW-1:0] dst;
      logic                  wr;
      logic                  load;
      logic                  halt;
   } stage_entry_t;

   // Width of one forwarding select: must encode 0 (register file) and
   // every stage number 1..ex_stages.
   function automatic int fwd_width(input int ex_stages);
      return (ex_stages < 1) ? 1 : $clog2(ex_stages + 1);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the decode stage and the hazard unit.
// master = decode stage / driver, slave = hazard controller.
interface pipe_hazard_ctrl_if
   import risc_pipe_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int NUM_RD    = 2,
   parameter int EX_STAGES = 2
);

   localparam int FW = fwd_width(EX_STAGES);

   logic                     en;
   logic                     id_valid;
   logic [NUM_RD*REG_AW-1:0] id_src;
   logic [NUM_RD-1:0]        id_src_used;
   logic [REG_AW-1:0]        id_dst;
   logic                     id_wr;
   logic                     id_load;
   logic                     id_halt;
   logic                     br_taken;

   logic                     id_fire;
   logic                     id_stall;
   logic                     flush_if;
   logic                     flush_id;
   logic [NUM_RD*FW-1:0]     fwd_sel;
   logic                     halt;

   modport master (
      output en, id_valid, id_src, id_src_used, id_dst, id_wr, id_load,
             id_halt, br_taken,
      input  id_fire, id_stall, flush_if, flush_id, fwd_sel, halt
   );

   modport slave (
      input  en, id_valid, id_src, id_src_used, id_dst, id_wr, id_load,
             id_halt, br_taken,
      output id_fire, id_stall, flush_if, flush_id, fwd_sel, halt
   );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Priority match of one read port against the in-flight tracker.
// The youngest (lowest-numbered) stage writing the source register wins;
// a load in that stage that is still too close to produce its data makes
// the port not ready, which the top turns into a load-use stall.
module fwd_match
   import risc_pipe_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int EX_STAGES = 2,
   parameter int LOAD_LAT  = 1,
   parameter int FW        = fwd_width(EX_STAGES)
)(
   input  logic                          [REG_AW-1:0] src,
   input  logic                                       used,
   input  stage_entry_t [EX_STAGES-1:0]               stages,
   output logic                          [FW-1:0]     sel,
   output logic                                       ready
);

   logic [MAX_REG_AW-1:0] src_ext;
   logic [EX_STAGES-1:0]  hit;
   logic [EX_STAGES-1:0]  unused_halt_bits;

   assign src_ext = MAX_REG_AW'(src);

   // Register 0 never creates a dependency, nor does an immediate operand.
   always_comb begin
      for (int k = 0; k < EX_STAGES; k++) begin
         hit[k] = used && (src != '0) && stages[k].valid && stages[k].wr &&
                  (stages[k].dst == src_ext);
      end
   end

   // The halt flag travels with the entry but plays no part in matching.
   always_comb begin
      for (int k = 0; k < EX_STAGES; k++) begin
         unused_halt_bits[k] = stages[k].halt;
      end
   end

   // Walk oldest to youngest so the youngest matching stage is the last
   // one written and therefore the one that decides sel/ready.
   always_comb begin
      sel   = FW'(FWD_RF);
      ready = 1'b1;
      for (int k = EX_STAGES - 1; k >= 0; k--) begin
         if (hit[k]) begin
            if (stages[k].load && ((k + 1) <= LOAD_LAT)) begin
               ready = 1'b0;
               sel   = FW'(FWD_RF);
            end else begin
               ready = 1'b1;
               sel   = FW'(k + 1);
            end
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow-control unit sitting beside decode.
// Tracks destinations of in-flight instructions, produces per-port
// forwarding selects, load-use stalls, branch flushes with an IF shadow,
// and a sticky halt after a run of retired halt instructions.
module pipe_hazard_ctrl
   import risc_pipe_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int NUM_RD    = 2,
   parameter int EX_STAGES = 2,
   parameter int LOAD_LAT  = 1,
   parameter int IF_LAT    = 1,
   parameter int HALT_RUN  = 4
)(
   input  logic               clk,
   input  logic               rst,
   pipe_hazard_ctrl_if.slave  bus
);

   localparam int FW   = fwd_width(EX_STAGES);
   localparam int SHW  = $clog2(IF_LAT + 2);
   localparam int RUNW = $clog2(HALT_RUN + 2);

   localparam logic [SHW-1:0]  SHADOW_LOAD = SHW'(IF_LAT);
   localparam logic [RUNW-1:0] RUN_MAX     = RUNW'(HALT_RUN);

   stage_entry_t [EX_STAGES-1:0] stages_q;
   stage_entry_t                 new_entry;

   logic [SHW-1:0]       shadow_q;
   logic [RUNW-1:0]      run_q;
   logic [RUNW-1:0]      run_d;
   logic                 halt_q;

   logic [NUM_RD-1:0]    port_ready;
   logic [NUM_RD*FW-1:0] sel_bus;
   logic                 all_ready;
   logic                 issue_ok;
   logic                 fire;

   // One priority matcher per read port, all looking at the same tracker.
   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_port
         fwd_match #(
            .REG_AW    (REG_AW),
            .EX_STAGES (EX_STAGES),
            .LOAD_LAT  (LOAD_LAT),
            .FW        (FW)
         ) u_match (
            .src    (bus.id_src[i*REG_AW +: REG_AW]),
            .used   (bus.id_src_used[i]),
            .stages (stages_q),
            .sel    (sel_bus[i*FW +: FW]),
            .ready  (port_ready[i])
         );
      end
   endgenerate

   // A taken branch or a halted core blocks issue; a branch therefore wins
   // over a load-use stall and lets a bubble into stage 1.
   assign all_ready = &port_ready;
   assign issue_ok  = bus.en & bus.id_valid & ~halt_q & ~bus.br_taken;
   assign fire      = issue_ok & all_ready;

   assign bus.id_fire  = fire;
   assign bus.id_stall = issue_ok & ~all_ready;
   assign bus.flush_id = bus.en & bus.br_taken;
   assign bus.flush_if = bus.en & (bus.br_taken | (shadow_q != '0));
   assign bus.fwd_sel  = sel_bus;
   assign bus.halt     = halt_q;

   // Entry that enters stage 1: the decoded instruction when it fires,
   // otherwise an all-zero bubble.
   always_comb begin
      new_entry = '0;
      if (fire) begin
         new_entry.valid = 1'b1;
         new_entry.dst   = MAX_REG_AW'(bus.id_dst);
         new_entry.wr    = bus.id_wr;
         new_entry.load  = bus.id_load;
         new_entry.halt  = bus.id_halt;
      end
   end

   // Halt-run bookkeeping for the entry leaving the last stage: halts
   // extend the run (saturating), any other real instruction breaks it,
   // bubbles are ignored.
   always_comb begin
      run_d = run_q;
      if (stages_q[EX_STAGES-1].valid) begin
         if (!stages_q[EX_STAGES-1].halt) begin
            run_d = '0;
         end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
         end
      end
   end

   // In-flight tracker: shifts one stage per enabled cycle, the oldest
   // entry falls off the end (retires). Reset drops everything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stages_q <= '0;
      end else if (bus.en) begin
         stages_q[0] <= new_entry;
         for (int k = 1; k < EX_STAGES; k++) begin
            stages_q[k] <= stages_q[k-1];
         end
      end
   end

   // Fetch shadow: keeps flush_if asserted for IF_LAT enabled cycles after
   // the branch so instructions already in the fetch pipe are squashed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
      end else if (bus.en) begin
         if (bus.br_taken) begin
            shadow_q <= SHADOW_LOAD;
         end else if (shadow_q != '0) begin
            shadow_q <= shadow_q - 1'b1;
         end
      end
   end

   // Halt-run counter and the sticky halt flag it sets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q  <= '0;
         halt_q <= 1'b0;
      end else if (bus.en) begin
         run_q <= run_d;
         if (run_d == RUN_MAX) begin
            halt_q <= 1'b1;
         end
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and flow-control unit for the next-generation pipelined RISC core. It sits beside the decode stage. It tracks the destination register of every in-flight instruction over a configurable number of post-decode stages and produces per-read-port forwarding selects. It also generates load-use stalls, branch flushes with a configurable instruction-fetch shadow, and a sticky halt when a run of halt instructions has retired.

## Interface
- `REG_AW`, 5, register-address width; register 0 is hard-wired zero.
- `NUM_RD`, 2, read ports per instruction.
- `EX_STAGES`, 2, post-decode stages holding unretired results; stage 1 is EX, stage `EX_STAGES` retires.
- `LOAD_LAT`, 1, extra stages before a load result is forwardable.
- `IF_LAT`, 1, instruction-fetch latency; extra cycles `flush_if` is held after a branch.
- `HALT_RUN`, 4, consecutive retired halt instructions that assert `halt`.
- `FW`, derived, `$clog2(EX_STAGES+1)`, forwarding-select width.

Ports:
- `clk` in 1: clock; one clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: pipeline enable; 0 freezes all state.
- `id_valid` in 1: decode holds a real instruction.
- `id_src` in `NUM_RD*REG_AW`: source registers; port i is at `[i*REG_AW +: REG_AW]`.
- `id_src_used` in `NUM_RD`: port i reads a register (0 means immediate or PC operand).
- `id_dst` in `REG_AW`: destination register.
- `id_wr` in 1: instruction writes `id_dst`.
- `id_load` in 1: instruction is a memory load.
- `id_halt` in 1: instruction is the halt word.
- `br_taken` in 1: branch/jump resolved taken in stage 1.
- `id_fire` out 1: decode instruction enters stage 1 this cycle.
- `id_stall` out 1: hold the IF/ID registers.
- `flush_if` out 1: squash the fetched instruction.
- `flush_id` out 1: squash the decode instruction.
- `fwd_sel` out `NUM_RD*FW`: per-port operand source; 0 is the register file, k is the stage-k result.
- `halt` out 1: registered, sticky.

## Operation
- **Tracker.** Shift register of `EX_STAGES` entries, each holding {valid, dst, wr, load, halt}. On each `en` cycle, entry k moves to k+1 and entry `EX_STAGES` retires.
  - Entry 1 loads the decode fields when `id_fire`=1, otherwise a bubble (valid=0).
- **Match.** For port i with `id_src_used[i]`=1 and a nonzero source, find the lowest k with valid, wr and dst equal to the source.
  - No match: `fwd_sel[i]`=0.
  - A match is ready if load=0, or if k > `LOAD_LAT`.
  - Ready: `fwd_sel[i]`=k. Not ready: stall.
- **Stall.** `id_stall` = en & id_valid & ~halt & ~br_taken & (any port not ready).
- **Fire.** `id_fire` = en & id_valid & ~halt & ~br_taken & ~id_stall.
- **Branch.** When `br_taken`=1 and `en`=1:
  - `flush_id`=1 and `flush_if`=1 this cycle.
  - Shadow counter loads `IF_LAT`; `flush_if` stays 1 while counter≠0, decrementing per `en` cycle.
  - A new `br_taken` while the counter is nonzero reloads it.
- **Halt.** Run counter, saturating at `HALT_RUN`.
  - Retiring valid halt entry: increment.
  - Retiring valid non-halt entry: clear.
  - Bubble: no change.
  - Counter reaching `HALT_RUN` sets `halt`; it holds until `rst`.
- **Disable.** `en`=0: no state change; `id_fire`, `id_stall`, `flush_*` are all 0; `fwd_sel` is still computed.

## Timing
- `fwd_sel`, `id_stall`, `id_fire`, `flush_id` are combinational from inputs and state, zero latency. `flush_if` is also combinational but extends `IF_LAT` cycles past `br_taken` via the shadow counter.
- `halt` rises on the clock edge at which the `HALT_RUN`-th halt retires.
- Load-use: a dependent instruction stalls for `LOAD_LAT` cycles, then fires with `fwd_sel`=`LOAD_LAT`+1.
- **Reset values.**
  - All entries invalid; counters 0; `halt`=0.
  - Outputs: `fwd_sel`=0, `flush_*`=0.
  - `id_fire`, `id_stall` evaluate combinationally; both are 0 with `en`=0 or `id_valid`=0.
- **Reset mid-operation.** `rst` discards in-flight entries immediately; no retirement is counted.
- **Simultaneous `br_taken` and a stall condition.** The branch wins: stall 0, fire 0, bubble into stage 1.

## Structure
- Package `risc_pipe_pkg`:
  - stage-entry struct typedef;
  - `FW` computation function;
  - `fwd_sel` encoding constant `FWD_RF`=0.
- Sub-module `fwd_match`: one read port's priority match over the tracker; outputs sel and ready. Instantiated `NUM_RD` times with generate.

## Test plan
- **Reset:** assert `rst` with `id_valid`=1 → `halt`=0, `fwd_sel`=0, `flush_*`=0. After release, a no-dependency instruction gives `id_fire`=1.
- **ALU chain:** fire dst=3 wr; next instruction src0=3 → `fwd_sel[0]`=1, no stall. The following one reads 3 → sel=2. The one after → sel=0.
- **Load-use** (`LOAD_LAT`=1): load dst=5; next src1=5 → `id_stall`=1 for exactly 1 cycle, then fires with `fwd_sel[1]`=2.
- **Zero register / unused port:** dst=0 wr followed by src=0, and `id_src_used`=0 on a matching register → sel 0, no stall.
- **Branch:** `br_taken`=1 concurrent with a load-use stall → `id_stall`=0, `id_fire`=0, `flush_id`=1 for 1 cycle, `flush_if`=1 for 2 cycles (`IF_LAT`=1). Stage 1 gets a bubble.
- **Halt:** 3 halts retire, then an ALU instruction → `halt` stays 0. Then 4 consecutive halts → `halt`=1 at the 4th retire edge, `id_fire` forced 0 afterward. `en`=0 for 3 cycles midway stretches timing with no miscount.
